// File: rtl/result_unloader.sv
// result_unloader: snapshots the four data register bank outputs on the
// network done pulse and streams them to the host over valid/ready.
// Optional build macro: RESULT_CHECKSUM_EN appends an XOR checksum word
// (out_index 0, flagged by out_is_sum) before the completion pulse.
module result_unloader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  input  logic [WORD_W-1:0] data2,
  input  logic [WORD_W-1:0] data3,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              unload_done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic              out_is_sum
`endif
);

  localparam int unsigned IDX_W    = 2;
  localparam int unsigned LAST_IDX = NUM_WORDS - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   snap_q [NUM_WORDS];
  logic [WORD_W-1:0]   snap_d [NUM_WORDS];
  logic [WORD_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer_c;
  logic                last_word_c;
  logic [IDX_W-1:0]    idx_next_c;

`ifdef RESULT_CHECKSUM_EN
  logic                sum_q, sum_d;
  logic [WORD_W-1:0]   sum_c;

  // XOR of the captured words, offered as the trailing checksum word
  always_comb begin
    sum_c = snap_q[0] ^ snap_q[1] ^ snap_q[2] ^ snap_q[3];
  end

  // The run ends only once the checksum word has been accepted
  assign last_word_c = sum_q;
  assign out_is_sum  = sum_q;
`else
  // The run ends when the highest-index word is accepted
  assign last_word_c = (idx_q == IDX_W'(LAST_IDX));
`endif

  assign xfer_c     = valid_q & out_ready;
  assign idx_next_c = idx_q + IDX_W'(1);

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) snap_q[i] <= '0;
`ifdef RESULT_CHECKSUM_EN
      sum_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
`ifdef RESULT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state: capture on start, leave SEND after the final transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND;
      SEND:    if (xfer_c && last_word_c) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; everything holds unless a transfer occurs
  always_comb begin
    snap_d  = snap_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef RESULT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d[0] = data0;
          snap_d[1] = data1;
          snap_d[2] = data2;
          snap_d[3] = data3;
          data_d    = data0;
          idx_d     = '0;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SEND: begin
        if (xfer_c) begin
          if (last_word_c) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
`ifdef RESULT_CHECKSUM_EN
            sum_d   = 1'b0;
`endif
          end
`ifdef RESULT_CHECKSUM_EN
          else if (idx_q == IDX_W'(LAST_IDX)) begin
            data_d = sum_c;
            idx_d  = '0;
            sum_d  = 1'b1;
          end
`endif
          else begin
            idx_d  = idx_next_c;
            data_d = snap_q[idx_next_c];
          end
        end
      end
      FINISH: begin
        busy_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign out_data    = data_q;
  assign out_index   = idx_q;
  assign out_valid   = valid_q;
  assign busy        = busy_q;
  assign unload_done = done_q;

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader; expected words are hand-written per test.
// Build with RESULT_CHECKSUM_EN defined to exercise the checksum word.
module tb_result_unloader;

`ifdef RESULT_CHECKSUM_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] data0 = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [31:0] data3 = '0;
  logic [31:0] out_data;
  logic [1:0]  out_index;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        unload_done;
  logic        sum_flag;
`ifdef RESULT_CHECKSUM_EN
  logic        out_is_sum;
  assign sum_flag = out_is_sum;
`else
  assign sum_flag = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] got_d [8];
  logic [1:0]  got_i [8];
  logic        got_s [8];

  result_unloader #(.WORD_W(32), .NUM_WORDS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .data3       (data3),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .unload_done (unload_done)
`ifdef RESULT_CHECKSUM_EN
    ,
    .out_is_sum  (out_is_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run: pulse start, optionally stall/restart/scramble, then
  // compare the accepted word stream and completion pulse against expectations.
  task automatic run_unload(input string name,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [31:0] esum,
                            input int stall_idx, input int stall_len,
                            input bit restart, input bit scramble,
                            input bit check_busy);
    logic [31:0] exp_w [5];
    int n_got, done_cnt, stalls, busy_cyc, extra_done;
    bit restarted, finished;
    exp_w[0] = d0; exp_w[1] = d1; exp_w[2] = d2; exp_w[3] = d3; exp_w[4] = esum;
    data0 = d0; data1 = d1; data2 = d2; data3 = d3;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    if (scramble) begin
      data0 = 32'hFFFF_FFFF; data1 = 32'hFFFF_FFFF;
      data2 = 32'hFFFF_FFFF; data3 = 32'hFFFF_FFFF;
    end
    check({name, "_first_valid"}, 32'(out_valid), 32'd1);
    check({name, "_first_index"}, 32'(out_index), 32'd0);
    n_got = 0; done_cnt = 0; stalls = 0; busy_cyc = 0;
    restarted = 1'b0; finished = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = 1'b1;
      if (out_valid && int'(out_index) == stall_idx && stalls < stall_len) begin
        out_ready = 1'b0;
        stalls++;
        check({name, "_stall_data"}, out_data, exp_w[stall_idx]);
        check({name, "_stall_index"}, 32'(out_index), 32'(stall_idx));
      end
      if (restart && !restarted && out_valid && out_index == 2'd2) begin
        start = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (unload_done) begin
        done_cnt++;
        check({name, "_done_after_last"}, 32'(n_got), 32'(NW));
      end
      if (out_valid && out_ready) begin
        if (n_got < 8) begin
          got_d[n_got] = out_data;
          got_i[n_got] = out_index;
          got_s[n_got] = sum_flag;
        end
        n_got++;
      end
      step();
      if (done_cnt > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check({name, "_finished_in_budget"}, 32'(finished), 32'd1);
    check({name, "_busy_low_after"}, 32'(busy), 32'd0);
    extra_done = 0;
    for (int c = 0; c < 3; c++) begin
      if (unload_done || out_valid) extra_done++;
      step();
    end
    check({name, "_quiet_after"}, 32'(extra_done), 32'd0);
    check({name, "_word_count"}, 32'(n_got), 32'(NW));
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    if (check_busy) check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(NW + 1));
    for (int i = 0; i < NW && i < n_got && i < 8; i++) begin
      check({name, "_data"}, got_d[i], exp_w[i]);
      check({name, "_index"}, 32'(got_i[i]), (i < 4) ? 32'(i) : 32'd0);
      check({name, "_is_sum"}, 32'(got_s[i]), (i == 4) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int aborted_done;
    reset = 1'b1;
    step();
    step();
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_index", 32'(out_index), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(unload_done), 32'd0);
    check("reset_is_sum", 32'(sum_flag), 32'd0);
    reset = 1'b0;
    step();

    // 0x11^0x22^0x33^0x44 = 0x44
    run_unload("basic", 32'h11, 32'h22, 32'h33, 32'h44, 32'h44, -1, 0, 1'b0, 1'b0, 1'b1);
    run_unload("backpressure", 32'h11, 32'h22, 32'h33, 32'h44, 32'h44, 1, 3, 1'b0, 1'b0, 1'b0);
    run_unload("snapshot", 32'h11, 32'h22, 32'h33, 32'h44, 32'h44, -1, 0, 1'b0, 1'b1, 1'b1);
    run_unload("restart_busy", 32'h11, 32'h22, 32'h33, 32'h44, 32'h44, -1, 0, 1'b1, 1'b0, 1'b1);

    // Abort a run with word 1 on offer
    data0 = 32'h11; data1 = 32'h22; data2 = 32'h33; data3 = 32'h44;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("abort_pre_index", 32'(out_index), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_out_data", out_data, 32'd0);
    check("abort_out_index", 32'(out_index), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(unload_done), 32'd0);
    step();
    step();
    reset = 1'b0;
    aborted_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (unload_done || busy) aborted_done++;
      step();
    end
    check("abort_no_done", 32'(aborted_done), 32'd0);
    // 0xA^0xB^0xC^0xD = 0x0
    run_unload("after_reset", 32'hA, 32'hB, 32'hC, 32'hD, 32'h0, -1, 0, 1'b0, 1'b0, 1'b1);

    // 0x1^0x2^0x4^0x8 = 0xF
    run_unload("checksum", 32'h1, 32'h2, 32'h4, 32'h8, 32'h0000_000F, -1, 0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Readout path at the far end of the network: the counterpart of the ROM loader that fills the data register bank.
- On the network's completion pulse, snapshots the four 32-bit layer outputs from the data register bank.
- Streams the snapshot out one word at a time over a valid/ready handshake, then pulses a completion flag.
- Sits between the data register bank outputs (data0..data3) and the host/test interface.

Parameters:
- WORD_W, 32, width of each data word
- NUM_WORDS, 4, number of words unloaded per run; fixed at 4 and must match the bank depth

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse from the network done signal
- data0  input  WORD_W  data register bank output 0
- data1  input  WORD_W  data register bank output 1
- data2  input  WORD_W  data register bank output 2
- data3  input  WORD_W  data register bank output 3
- out_data  output  WORD_W  word currently offered
- out_index  output  2  index (0..3) of the word in out_data
- out_valid  output  1  out_data/out_index are valid
- out_ready  input  1  consumer accepts the word when high together with out_valid
- busy  output  1  high from capture until the completion pulse ends
- unload_done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE
  - out_data = 0, out_index = 0, out_valid = 0, busy = 0, unload_done = 0
  - snapshot registers cleared
- States: IDLE, SEND, FINISH.
- IDLE:
  - start sampled high at edge k: data0..data3 latched into snapshot[0..3] at edge k.
  - Same edge: state -> SEND, out_index = 0, out_data = snapshot[0], out_valid = 1, busy = 1.
  - First word is therefore visible in the cycle after start is asserted (latency 1).
- SEND:
  - A transfer occurs on an edge where out_valid & out_ready.
  - Index i < 3: out_index -> i+1, out_data -> snapshot[i+1], out_valid stays 1. This allows back-to-back transfers at one word per cycle.
  - Index 3: out_valid -> 0, state -> FINISH.
  - out_ready low: out_data, out_index and out_valid hold; they must not change while the word is stalled.
- FINISH:
  - unload_done = 1 for exactly one cycle.
  - Next edge: state -> IDLE, busy = 0, unload_done = 0.
- start while busy = 1 is ignored. No re-snapshot and no queuing.
- Changes on data0..data3 after capture do not affect the words being sent.
- out_ready is don't-care while out_valid = 0.
- Reset asserted mid-SEND aborts the run immediately. No unload_done is produced. A later start begins again at index 0.
- Minimum run with out_ready held high: start -> 4 transfer cycles -> 1 FINISH cycle. busy is high for 5 cycles.

Optional Feature:
- Macro: RESULT_CHECKSUM_EN
- Defined:
  - After word 3 is accepted, a fifth word is sent at out_index = 0 with the same handshake rules.
  - The fifth word is the XOR of snapshot[0..3].
  - Adds a 1-bit output out_is_sum, high only while the checksum word is offered (reset 0).
  - FINISH is entered only after the checksum word is accepted.
  - busy lasts 6 cycles with out_ready held high.
- Not defined: no checksum word and no out_is_sum port. Behaviour is exactly as above.

Test Plan:
- Basic unload:
  - Stimulus: reset, then data0..3 = 0x00000011, 0x00000022, 0x00000033, 0x00000044; pulse start; out_ready held 1.
  - Required: out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_index 0..3; unload_done pulses once in the 5th cycle after start; busy low afterwards.
- Backpressure:
  - Stimulus: same data; out_ready low for 3 cycles while word 1 is offered.
  - Required: out_data holds 0x22 and out_index holds 1 throughout the stall; all four words arrive in order with no duplicates or drops.
- Snapshot isolation:
  - Stimulus: after start, change data0..3 to 0xFFFFFFFF.
  - Required: the original four values are still delivered.
- start while busy:
  - Stimulus: pulse start again while word 2 is pending.
  - Required: ignored; exactly 4 transfers and 1 unload_done.
- Mid-run reset:
  - Stimulus: assert reset during word 1, release it, then pulse start with data0..3 = 0xA, 0xB, 0xC, 0xD.
  - Required: all outputs read 0 during reset; no unload_done from the aborted run; new run delivers 0xA..0xD starting at index 0.
- RESULT_CHECKSUM_EN:
  - Stimulus: data0..3 = 0x1, 0x2, 0x4, 0x8.
  - Required: fifth word 0x0000000F with out_is_sum = 1; unload_done follows acceptance of that word.
